// File: rtl/compnb_seq.sv
// compnb_seq: multi-cycle magnitude comparator.
//
// Compares two WIDTH-bit operands SLICE bits per clock, most-significant
// slice first, and stops at the first slice that differs. Signed compares
// flip the sign bit of both operands at capture (offset binary), so the
// slice datapath is always an unsigned compare.
//
// Ports:
//   clk    in   rising-edge clock
//   rst_n  in   asynchronous active-low reset
//   start  in   request strobe, accepted only while idle
//   sgn    in   1 = two's-complement compare, 0 = unsigned (sampled with start)
//   a, b   in   WIDTH-bit operands (sampled with start)
//   busy   out  high while a compare is in progress
//   done   out  one-cycle pulse when gt/lt/eq have just been updated
//   gt     out  A > B (registered, held until the next done)
//   lt     out  A < B (registered, held until the next done)
//   eq     out  A == B (registered, held until the next done)
module compnb_seq #(
    parameter int WIDTH = 16,
    parameter int SLICE = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic             sgn,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
    output logic             gt,
    output logic             lt,
    output logic             eq
);

    localparam int NSLICE = WIDTH / SLICE;
    localparam int IDXW   = (NSLICE > 1) ? $clog2(NSLICE) : 1;
    localparam logic [IDXW-1:0] IDX_TOP  = IDXW'(NSLICE - 1);
    localparam logic [IDXW-1:0] IDX_ZERO = {IDXW{1'b0}};
    localparam logic [IDXW-1:0] IDX_ONE  = IDXW'(1);

    typedef enum logic [0:0] {
        S_IDLE = 1'b0,
        S_RUN  = 1'b1
    } state_t;

    state_t           state_r;
    state_t           state_nxt_s;
    logic [IDXW-1:0]  idx_r;
    logic [IDXW-1:0]  idx_nxt_s;
    logic [WIDTH-1:0] a_r;
    logic [WIDTH-1:0] b_r;
    logic [WIDTH-1:0] a_nxt_s;
    logic [WIDTH-1:0] b_nxt_s;
    logic [SLICE-1:0] slice_a_s;
    logic [SLICE-1:0] slice_b_s;
    logic             slice_ne_s;
    logic             slice_gt_s;
    logic             last_s;
    logic             busy_nxt_s;
    logic             done_nxt_s;
    logic             gt_nxt_s;
    logic             lt_nxt_s;
    logic             eq_nxt_s;

    // Offset-binary mapping: flipping the MSB turns a signed order into an unsigned one.
    function automatic logic [WIDTH-1:0] to_offset(input logic [WIDTH-1:0] v, input logic s);
        logic [WIDTH-1:0] r;
        r            = v;
        r[WIDTH-1]   = v[WIDTH-1] ^ s;
        return r;
    endfunction

    // Select the slice currently addressed by idx_r (constant-index mux).
    always_comb begin
        slice_a_s = {SLICE{1'b0}};
        slice_b_s = {SLICE{1'b0}};
        for (int i = 0; i < NSLICE; i++) begin
            if (idx_r == IDXW'(i)) begin
                slice_a_s = a_r[i*SLICE +: SLICE];
                slice_b_s = b_r[i*SLICE +: SLICE];
            end else begin
                slice_a_s = slice_a_s;
                slice_b_s = slice_b_s;
            end
        end
    end

    assign slice_ne_s = (slice_a_s != slice_b_s);
    assign slice_gt_s = (slice_a_s > slice_b_s);
    assign last_s     = (idx_r == IDX_ZERO);

    // State register and captured operands / slice index.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_r <= S_IDLE;
            idx_r   <= IDX_ZERO;
            a_r     <= {WIDTH{1'b0}};
            b_r     <= {WIDTH{1'b0}};
        end else begin
            state_r <= state_nxt_s;
            idx_r   <= idx_nxt_s;
            a_r     <= a_nxt_s;
            b_r     <= b_nxt_s;
        end
    end

    // Next-state logic: capture on start in IDLE, walk slices downward in RUN.
    always_comb begin
        state_nxt_s = state_r;
        idx_nxt_s   = idx_r;
        a_nxt_s     = a_r;
        b_nxt_s     = b_r;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    a_nxt_s     = to_offset(a, sgn);
                    b_nxt_s     = to_offset(b, sgn);
                    idx_nxt_s   = IDX_TOP;
                    state_nxt_s = S_RUN;
                end else begin
                    state_nxt_s = S_IDLE;
                end
            end
            S_RUN: begin
                if (slice_ne_s || last_s) begin
                    state_nxt_s = S_IDLE;
                end else begin
                    idx_nxt_s   = idx_r - IDX_ONE;
                    state_nxt_s = S_RUN;
                end
            end
            default: begin
                state_nxt_s = S_IDLE;
                idx_nxt_s   = IDX_ZERO;
            end
        endcase
    end

    // Output logic: next values of the registered handshake and result flags.
    always_comb begin
        busy_nxt_s = 1'b0;
        done_nxt_s = 1'b0;
        gt_nxt_s   = gt;
        lt_nxt_s   = lt;
        eq_nxt_s   = eq;
        case (state_r)
            S_IDLE: begin
                if (start) begin
                    busy_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b0;
                end
            end
            S_RUN: begin
                if (slice_ne_s) begin
                    gt_nxt_s   = slice_gt_s;
                    lt_nxt_s   = ~slice_gt_s;
                    eq_nxt_s   = 1'b0;
                    done_nxt_s = 1'b1;
                end else if (last_s) begin
                    gt_nxt_s   = 1'b0;
                    lt_nxt_s   = 1'b0;
                    eq_nxt_s   = 1'b1;
                    done_nxt_s = 1'b1;
                end else begin
                    busy_nxt_s = 1'b1;
                end
            end
            default: begin
                busy_nxt_s = 1'b0;
            end
        endcase
    end

    // Registered outputs, so there is no combinational path from inputs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            busy <= 1'b0;
            done <= 1'b0;
            gt   <= 1'b0;
            lt   <= 1'b0;
            eq   <= 1'b0;
        end else begin
            busy <= busy_nxt_s;
            done <= done_nxt_s;
            gt   <= gt_nxt_s;
            lt   <= lt_nxt_s;
            eq   <= eq_nxt_s;
        end
    end

endmodule
